ecc_42_enc_pipe: RTL and testbench

Write-side SECDED encoder stage for the 42-bit FIFO data path. It registers each accepted word together with its 7-bit parity behind a valid/ready skid buffer. It runs two redundant encoders in lockstep and flags any mismatch. It also provides a one-shot error-injection mechanism so the read-side decoder and its fault detection can be exercised in silicon. It sits between the FIFO producer and the RAM write port.

---
 rtl/ecc_42_pkg.sv | 32 +++
 rtl/ecc_42_enc.sv | 17 +
 rtl/ecc_42_enc_pipe.sv | 99 +++++++++
 tb/tb_ecc_42_enc_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_42_pkg.sv
// ecc_42_pkg: shared SECDED constants, codeword position map and injection encodings
package ecc_42_pkg;
  localparam int DATA_WIDTH   = 42;
  localparam int PARITY_WIDTH = 7;
  localparam int CW_LAST      = DATA_WIDTH + PARITY_WIDTH - 1;

  typedef enum logic [1:0] {
    INJ_NONE = 2'b00,
    INJ_D0   = 2'b01,
    INJ_D10  = 2'b10,
    INJ_P6   = 2'b11
  } inj_mode_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [PARITY_WIDTH-1:0] parity;
    logic                    fault;
  } beat_t;

  // Codeword position of data bit k: the k-th non-power-of-two position starting at 3
  function automatic logic [5:0] data_pos(input int k);
    int n;
    n = 0;
    for (int p = 3; p <= CW_LAST; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) return p[5:0];
        n++;
      end
    end
    return 6'd0;
  endfunction
endpackage

// File: rtl/ecc_42_enc.sv
// ecc_42_enc: combinational SECDED parity generator for one 42-bit word
module ecc_42_enc
  import ecc_42_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [PARITY_WIDTH-1:0] o_parity
);
  logic [5:0] w_ham;

  // Each data bit toggles the Hamming bits selected by its codeword position
  always_comb begin
    w_ham = '0;
    for (int k = 0; k < DATA_WIDTH; k++) w_ham = w_ham ^ ({6{i_data[k]}} & data_pos(k));
  end

  assign o_parity = {^i_data ^ ^w_ham, w_ham};
endmodule

// File: rtl/ecc_42_enc_pipe.sv
// ecc_42_enc_pipe: lockstep SECDED encoder with skid buffer, one-shot injection and fault counter
module ecc_42_enc_pipe
  import ecc_42_pkg::*;
#(
  parameter int FAULT_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ecc_fault_detc_en,
  input  logic                       bypass,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [PARITY_WIDTH-1:0]    out_parity,
  output logic                       out_fault,
  input  logic                       inj_arm,
  input  logic [1:0]                 inj_mode,
  output logic                       inj_busy,
  input  logic                       dbg_force_mismatch,
  output logic                       ecc_fault,
  output logic [FAULT_CNT_WIDTH-1:0] fault_cnt,
  input  logic                       fault_clr
);
  logic [PARITY_WIDTH-1:0]    w_par0, w_par1_raw, w_par1;
  logic                       w_mis, w_acc, w_pop;
  inj_mode_e                  w_inj;
  beat_t                      w_beat, r_main, r_skid;
  logic                       r_main_v, r_skid_v, r_inj_busy, r_ecc_fault;
  inj_mode_e                  r_inj_mode;
  logic [FAULT_CNT_WIDTH-1:0] r_fault_cnt;

  ecc_42_enc u_enc0 (.i_data(in_data), .o_parity(w_par0));
  ecc_42_enc u_enc1 (.i_data(in_data), .o_parity(w_par1_raw));

  assign w_par1 = w_par1_raw ^ {{(PARITY_WIDTH-1){1'b0}}, dbg_force_mismatch};
  assign w_mis  = ecc_fault_detc_en & ~bypass & (w_par0 != w_par1);
  assign w_acc  = in_valid & ~r_skid_v;
  assign w_pop  = r_main_v & out_ready;
  assign w_inj  = r_inj_busy ? r_inj_mode : INJ_NONE;
  assign w_beat = {in_data ^ {{(DATA_WIDTH-2){1'b0}}, w_inj == INJ_D10, (w_inj == INJ_D0) | (w_inj == INJ_D10)},
                   (bypass ? {PARITY_WIDTH{1'b0}} : w_par0) ^ {w_inj == INJ_P6, {(PARITY_WIDTH-1){1'b0}}},
                   w_mis};

  // Two-entry skid buffer; skid only fills while main is occupied and stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_pop | ~r_main_v) begin
      r_main_v <= r_skid_v | w_acc;
      if (r_skid_v | w_acc) r_main <= r_skid_v ? r_skid : w_beat;
      r_skid_v <= 1'b0;
    end else if (w_acc) begin
      r_skid   <= w_beat;
      r_skid_v <= 1'b1;
    end
  end

  // One-shot injection: arm when idle, consume on the next accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_busy <= 1'b0;
      r_inj_mode <= INJ_NONE;
    end else if (r_inj_busy) begin
      if (w_acc) r_inj_busy <= 1'b0;
    end else if (inj_arm && inj_mode != INJ_NONE) begin
      r_inj_busy <= 1'b1;
      r_inj_mode <= inj_mode_e'(inj_mode);
    end
  end

  // Sticky fault flag and saturating count; a mismatched beat wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ecc_fault <= 1'b0;
      r_fault_cnt <= '0;
    end else if (w_acc & w_mis) begin
      r_ecc_fault <= 1'b1;
      r_fault_cnt <= fault_clr ? FAULT_CNT_WIDTH'(1) : (&r_fault_cnt ? r_fault_cnt : r_fault_cnt + 1'b1);
    end else if (fault_clr) begin
      r_ecc_fault <= 1'b0;
      r_fault_cnt <= '0;
    end
  end

  assign in_ready   = ~r_skid_v;
  assign out_valid  = r_main_v;
  assign out_data   = r_main.data;
  assign out_parity = r_main.parity;
  assign out_fault  = r_main.fault;
  assign inj_busy   = r_inj_busy;
  assign ecc_fault  = r_ecc_fault;
  assign fault_cnt  = r_fault_cnt;
endmodule

// File: tb/tb_ecc_42_enc_pipe.sv
// tb_ecc_42_enc_pipe: directed stimulus with a queue-based reference model checked every cycle
module tb_ecc_42_enc_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ecc_fault_detc_en = 1'b0, bypass = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        inj_arm = 1'b0, dbg_force_mismatch = 1'b0, fault_clr = 1'b0;
  logic [1:0]  inj_mode = 2'b00;
  logic [41:0] in_data = '0;
  logic        in_ready, out_valid, out_fault, inj_busy, ecc_fault;
  logic [41:0] out_data;
  logic [6:0]  out_parity;
  logic [7:0]  fault_cnt;

  int n_cmp = 0, n_err = 0;

  typedef struct {logic [41:0] d; logic [6:0] p; logic f;} exp_t;
  exp_t       q[$];
  bit         m_busy = 0, m_fault = 0;
  logic [1:0] m_mode = 2'b00;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  ecc_42_enc_pipe dut (
    .clk(clk), .rst_n(rst_n), .ecc_fault_detc_en(ecc_fault_detc_en), .bypass(bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_parity(out_parity),
    .out_fault(out_fault), .inj_arm(inj_arm), .inj_mode(inj_mode), .inj_busy(inj_busy),
    .dbg_force_mismatch(dbg_force_mismatch), .ecc_fault(ecc_fault), .fault_cnt(fault_cnt),
    .fault_clr(fault_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the 48-position codeword explicitly and XOR-reduce per position bit
  function automatic logic [6:0] ref_par(input logic [41:0] d);
    logic [48:0] cw;
    logic [6:0]  p;
    int          k;
    cw = '0;
    p  = '0;
    k  = 0;
    for (int pos = 1; pos <= 48; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    for (int pos = 1; pos <= 48; pos++)
      for (int i = 0; i < 6; i++)
        if (pos[i]) p[i] = p[i] ^ cw[pos];
    p[6] = ^cw ^ ^p[5:0];
    return p;
  endfunction

  // Compare against the model, then advance it to what the coming rising edge must do
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_busy  = 0;
      m_fault = 0;
      m_cnt   = 0;
    end else begin
      int   sz;
      bit   acc, pop, mis, was_busy;
      exp_t e;
      sz = q.size();
      chk("out_valid", out_valid, sz > 0);
      chk("in_ready", in_ready, sz < 2);
      chk("inj_busy", inj_busy, m_busy);
      chk("ecc_fault", ecc_fault, m_fault);
      chk("fault_cnt", fault_cnt, m_cnt);
      if (out_valid && sz > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_parity", out_parity, q[0].p);
        chk("out_fault", out_fault, q[0].f);
      end
      acc = in_valid && sz < 2;
      pop = out_ready && sz > 0;
      mis = ecc_fault_detc_en && !bypass && dbg_force_mismatch;
      was_busy = m_busy;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.d = in_data;
        e.p = bypass ? 7'h00 : ref_par(in_data);
        e.f = mis;
        if (was_busy) begin
          if (m_mode == 2'b01) e.d = e.d ^ 42'h1;
          if (m_mode == 2'b10) e.d = e.d ^ 42'h3;
          if (m_mode == 2'b11) e.p = e.p ^ 7'h40;
          m_busy = 0;
        end
        q.push_back(e);
      end
      if (!was_busy && inj_arm && inj_mode != 2'b00) begin
        m_busy = 1;
        m_mode = inj_mode;
      end
      if (acc && mis) begin
        m_fault = 1;
        m_cnt   = fault_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      end else if (fault_clr) begin
        m_fault = 0;
        m_cnt   = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [41:0] d);
    int n;
    bit a;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      a = in_ready;
      step();
      n++;
    end while (!a && n < 40);
    chk("send_accept", a, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [41:0] v;
    v = 42'h0; chk("pin_par0", ref_par(v), 7'h00);
    v = 42'h1; chk("pin_par1", ref_par(v), 7'h43);
    v = 42'h2; chk("pin_par2", ref_par(v), 7'h45);
    #2 rst_n = 1'b0;
    #1;
    chk("rst0_out_valid", out_valid, 0);
    chk("rst0_in_ready", in_ready, 1);
    chk("rst0_fault_cnt", fault_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    // basic encode
    send(42'h0); chk("enc0_par", out_parity, 7'h00); chk("enc0_fault", out_fault, 0);
    send(42'h1); chk("enc1_par", out_parity, 7'h43); chk("enc1_data", out_data, 42'h1);
    send(42'h2); chk("enc2_par", out_parity, 7'h45);
    send(42'h3FF_FFFF_FFFF);
    send(42'h2AA_AAAA_AAAA);
    step(); step();
    // backpressure
    out_ready = 1'b0;
    send(42'd10);
    send(42'd11);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b1; in_data = 42'd12;
    step();
    chk("bp_hold_data", out_data, 42'd10);
    chk("bp_still_blocked", in_ready, 0);
    out_ready = 1'b1;
    send(42'd12);
    send(42'd13);
    step(); step(); step();
    // injection modes
    inj_mode = 2'b00; inj_arm = 1'b1; step(); inj_arm = 1'b0;
    chk("inj_none_idle", inj_busy, 0);
    inj_mode = 2'b01; inj_arm = 1'b1; step(); inj_arm = 1'b0;
    chk("inj01_busy", inj_busy, 1);
    send(42'h0); chk("inj01_data", out_data, 42'h1); chk("inj01_par", out_parity, 7'h00); chk("inj01_clear", inj_busy, 0);
    send(42'h0); chk("inj01_next", out_data, 42'h0);
    inj_mode = 2'b10; inj_arm = 1'b1; step(); inj_arm = 1'b0;
    send(42'h0); chk("inj10_data", out_data, 42'h3);
    send(42'h0); chk("inj10_next", out_data, 42'h0);
    inj_mode = 2'b11; inj_arm = 1'b1; step(); inj_arm = 1'b0;
    send(42'h0); chk("inj11_par", out_parity, 7'h40); chk("inj11_data", out_data, 42'h0);
    inj_mode = 2'b01; inj_arm = 1'b1; step();
    inj_mode = 2'b11; step(); inj_arm = 1'b0;
    send(42'h0); chk("inj_rearm_ignored", out_data, 42'h1); chk("inj_rearm_par", out_parity, 7'h00);
    // mismatch detection
    ecc_fault_detc_en = 1'b1; dbg_force_mismatch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(42'(i + 100));
      chk("mis_out_fault", out_fault, 1);
    end
    chk("mis_sticky", ecc_fault, 1);
    chk("mis_cnt3", fault_cnt, 3);
    ecc_fault_detc_en = 1'b0;
    send(42'h55); chk("mis_disabled_fault", out_fault, 0); chk("mis_disabled_cnt", fault_cnt, 3);
    ecc_fault_detc_en = 1'b1; bypass = 1'b1;
    send(42'h1); chk("bypass_par", out_parity, 7'h00); chk("bypass_cnt", fault_cnt, 3);
    bypass = 1'b0;
    // clear and saturation
    fault_clr = 1'b1; send(42'h5); fault_clr = 1'b0;
    chk("clr_with_mis_cnt", fault_cnt, 1); chk("clr_with_mis_flag", ecc_fault, 1);
    dbg_force_mismatch = 1'b0; fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chk("clr_cnt", fault_cnt, 0); chk("clr_flag", ecc_fault, 0);
    dbg_force_mismatch = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 42'(i * 7919);
      step();
    end
    in_valid = 1'b0;
    chk("sat_cnt", fault_cnt, 8'hFF);
    dbg_force_mismatch = 1'b0; ecc_fault_detc_en = 1'b0;
    step();
    // reset mid-transfer
    out_ready = 1'b0;
    send(42'h7);
    send(42'h8);
    inj_mode = 2'b01; inj_arm = 1'b1; step(); inj_arm = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_busy", inj_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_inj_busy", inj_busy, 0);
    chk("rst_ecc_fault", ecc_fault, 0);
    chk("rst_fault_cnt", fault_cnt, 0);
    step(); step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    send(42'h1);
    chk("post_rst_data", out_data, 42'h1);
    chk("post_rst_par", out_parity, 7'h43);
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
